// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, decode resolution and perf signals of the next-PC predictor
interface branch_predictor_if #(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
);
  logic [XLEN-1:0]   if_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [XLEN-1:0]   pred_next_pc;
  logic              upd_valid;
  logic [XLEN-1:0]   upd_pc;
  logic              upd_is_branch;
  logic              upd_is_jump;
  logic              upd_taken;
  logic [XLEN-1:0]   upd_target;
  logic              upd_pred_taken;
  logic [XLEN-1:0]   upd_pred_target;
  logic              btb_flush;
  logic              mispredict;
  logic [XLEN-1:0]   redirect_pc;
  logic [PERF_W-1:0] perf_branches;
  logic [PERF_W-1:0] perf_mispredicts;
  modport master (
    output if_pc, upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken,
           upd_target, upd_pred_taken, upd_pred_target, btb_flush,
    input  pred_hit, pred_taken, pred_next_pc, mispredict, redirect_pc,
           perf_branches, perf_mispredicts
  );
  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken,
           upd_target, upd_pred_taken, upd_pred_target, btb_flush,
    output pred_hit, pred_taken, pred_next_pc, mispredict, redirect_pc,
           perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit bimodal counters, mispredict detect and perf counters
module branch_predictor #(
  parameter int         XLEN      = 32,
  parameter int         BTB_DEPTH = 16,
  parameter logic [1:0] CNT_INIT  = 2'b01,
  parameter int         PERF_W    = 32
) (
  input logic             clk,
  input logic             rst,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;
  logic [BTB_DEPTH-1:0] valid;
  logic [BTB_DEPTH-1:0] is_jump;
  logic [TAG_W-1:0]     tag    [BTB_DEPTH];
  logic [XLEN-1:0]      target [BTB_DEPTH];
  logic [1:0]           cnt    [BTB_DEPTH];
  logic [IDX_W-1:0]     l_idx, u_idx;
  logic [TAG_W-1:0]     l_tag, u_tag;
  logic                 u_en, u_hit, u_wr, n_jump;
  logic [1:0]           c_cur, n_cnt;
  logic [PERF_W-1:0]    perf_b, perf_m;
  always_comb begin
    l_idx = bp.if_pc[IDX_W+1:2];
    l_tag = bp.if_pc[XLEN-1:IDX_W+2];
    u_idx = bp.upd_pc[IDX_W+1:2];
    u_tag = bp.upd_pc[XLEN-1:IDX_W+2];
    bp.pred_hit     = valid[l_idx] && tag[l_idx] == l_tag;
    bp.pred_taken   = bp.pred_hit && (is_jump[l_idx] || cnt[l_idx][1]);
    bp.pred_next_pc = bp.pred_taken ? target[l_idx] : bp.if_pc + XLEN'(4);
    u_en  = bp.upd_valid && (bp.upd_is_branch || bp.upd_is_jump);
    u_hit = valid[u_idx] && tag[u_idx] == u_tag;
    u_wr  = u_en && (u_hit || bp.upd_taken);
    c_cur = cnt[u_idx];
    n_cnt = bp.upd_is_jump ? 2'b11 :
            !u_hit         ? 2'b10 :
            bp.upd_taken   ? (c_cur == 2'b11 ? c_cur : c_cur + 2'd1) :
                             (c_cur == 2'b00 ? c_cur : c_cur - 2'd1);
    n_jump = bp.upd_is_jump || (u_hit && is_jump[u_idx]);
    bp.mispredict  = u_en && (bp.upd_taken != bp.upd_pred_taken ||
                     (bp.upd_taken && bp.upd_target != bp.upd_pred_target));
    bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + XLEN'(4);
    bp.perf_branches    = perf_b;
    bp.perf_mispredicts = perf_m;
  end
  // flush wins over a same-cycle training write; reset wins over both
  always_ff @(posedge clk) begin
    if (rst || bp.btb_flush) begin
      valid <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) cnt[i] <= CNT_INIT;
    end else if (u_wr) begin
      valid[u_idx]   <= 1'b1;
      tag[u_idx]     <= u_tag;
      cnt[u_idx]     <= n_cnt;
      is_jump[u_idx] <= n_jump;
      if (bp.upd_taken || bp.upd_is_jump) target[u_idx] <= bp.upd_target;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_b <= '0;
      perf_m <= '0;
    end else begin
      if (u_en && perf_b != '1) perf_b <= perf_b + 1'b1;
      if (bp.mispredict && perf_m != '1) perf_m <= perf_m + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scoreboard bench for branch_predictor
module tb_branch_predictor;
  localparam int PW = 4;
  typedef struct { int k; logic [31:0] v; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   nb = 0;
  int   nm = 0;
  bit   pend_b = 0;
  bit   pend_m = 0;
  string names [7] = '{"pred_hit", "pred_taken", "pred_next_pc", "mispredict",
                       "redirect_pc", "perf_branches", "perf_mispredicts"};
  branch_predictor_if #(.XLEN(32), .PERF_W(PW)) bif ();
  branch_predictor #(.XLEN(32), .BTB_DEPTH(16), .CNT_INIT(2'b01), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .bp(bif)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] obs(int k);
    case (k)
      0: return {31'b0, bif.pred_hit};
      1: return {31'b0, bif.pred_taken};
      2: return bif.pred_next_pc;
      3: return {31'b0, bif.mispredict};
      4: return bif.redirect_pc;
      5: return 32'(bif.perf_branches);
      default: return 32'(bif.perf_mispredicts);
    endcase
  endfunction
  task automatic push(int k, logic [31:0] v);
    exp_t e;
    e.k = k;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic check();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.k);
      n_cmp++;
      assert (o === e.v) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", names[e.k], o, e.v);
      end
    end
  endtask
  task automatic look(logic [31:0] pc, bit hit, bit tk, logic [31:0] nxt);
    bif.if_pc = pc;
    push(0, {31'b0, hit});
    push(1, {31'b0, tk});
    push(2, nxt);
  endtask
  task automatic upd(logic [31:0] pc, bit br, bit jp, bit tk, logic [31:0] tgt,
                     bit ptk, logic [31:0] ptgt, bit misp);
    logic [31:0] redir;
    bif.upd_valid       = 1'b1;
    bif.upd_pc          = pc;
    bif.upd_is_branch   = br;
    bif.upd_is_jump     = jp;
    bif.upd_taken       = tk;
    bif.upd_target      = tgt;
    bif.upd_pred_taken  = ptk;
    bif.upd_pred_target = ptgt;
    redir = pc + 32'd4;
    if (tk) redir = tgt;
    push(3, {31'b0, misp});
    if (misp) push(4, redir);
    pend_b = br | jp;
    pend_m = misp;
  endtask
  task automatic tick();
    #4 check();
    @(posedge clk);
    #1;
    if (pend_b && nb != 2**PW - 1) nb++;
    if (pend_m && nm != 2**PW - 1) nm++;
    if (rst) begin
      nb = 0;
      nm = 0;
    end
    pend_b = 0;
    pend_m = 0;
    rst = 1'b0;
    bif.upd_valid = 1'b0;
    bif.btb_flush = 1'b0;
    push(5, nb);
    push(6, nm);
    check();
  endtask
  initial begin
    bif.if_pc = '0;
    bif.upd_valid = 1'b0;
    bif.upd_pc = '0;
    bif.upd_is_branch = 1'b0;
    bif.upd_is_jump = 1'b0;
    bif.upd_taken = 1'b0;
    bif.upd_target = '0;
    bif.upd_pred_taken = 1'b0;
    bif.upd_pred_target = '0;
    bif.btb_flush = 1'b0;
    repeat (2) @(posedge clk);
    tick();
    look(32'h100, 0, 0, 32'h104); tick();
    look(32'h100, 0, 0, 32'h104); upd(32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 1); tick();
    look(32'h100, 1, 1, 32'h80);  upd(32'h100, 1, 0, 0, 32'h0, 1, 32'h80, 1); tick();
    look(32'h100, 1, 0, 32'h104); upd(32'h100, 1, 0, 0, 32'h0, 0, 32'h104, 0); tick();
    look(32'h100, 1, 0, 32'h104); upd(32'h100, 1, 0, 0, 32'h0, 0, 32'h104, 0); tick();
    look(32'h100, 1, 0, 32'h104); upd(32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 1); tick();
    look(32'h100, 1, 0, 32'h104); upd(32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 1); tick();
    look(32'h100, 1, 1, 32'h80);  upd(32'h100, 1, 0, 1, 32'h80, 1, 32'h80, 0); tick();
    look(32'h100, 1, 1, 32'h80);  upd(32'h100, 1, 0, 1, 32'h80, 1, 32'h80, 0); tick();
    look(32'h100, 1, 1, 32'h80);  upd(32'h100, 1, 0, 0, 32'h0, 1, 32'h80, 1); tick();
    look(32'h100, 1, 1, 32'h80);  upd(32'h100, 1, 0, 0, 32'h0, 1, 32'h80, 1); tick();
    look(32'h100, 1, 0, 32'h104); tick();
    look(32'h200, 0, 0, 32'h204); upd(32'h200, 0, 1, 1, 32'h400, 0, 32'h204, 1); tick();
    look(32'h200, 1, 1, 32'h400); upd(32'h200, 0, 1, 1, 32'h500, 1, 32'h400, 1); tick();
    look(32'h200, 1, 1, 32'h500); tick();
    look(32'h100, 0, 0, 32'h104); tick();
    look(32'h40, 0, 0, 32'h44);   upd(32'h40, 1, 0, 1, 32'h1000, 0, 32'h44, 1); tick();
    look(32'h40, 1, 1, 32'h1000); tick();
    look(32'h80, 0, 0, 32'h84);   upd(32'h80, 1, 0, 1, 32'h2000, 0, 32'h84, 1); tick();
    look(32'h80, 1, 1, 32'h2000); tick();
    look(32'h40, 0, 0, 32'h44);   tick();
    look(32'h80, 1, 1, 32'h2000); upd(32'h80, 0, 0, 1, 32'h3000, 0, 32'h84, 0); tick();
    look(32'h80, 1, 1, 32'h2000); tick();
    bif.btb_flush = 1'b1;
    look(32'h80, 1, 1, 32'h2000); upd(32'h300, 1, 0, 1, 32'h4000, 0, 32'h304, 1); tick();
    look(32'h80, 0, 0, 32'h84);   tick();
    look(32'h300, 0, 0, 32'h304); tick();
    for (int i = 0; i < 16; i++) begin
      upd(32'h500, 1, 0, 1, 32'h900, 0, 32'h504, 1);
      tick();
    end
    look(32'h500, 1, 1, 32'h900); tick();
    look(32'hFFFF_FFFC, 0, 0, 32'h0);
    upd(32'hFFFF_FFFC, 1, 0, 0, 32'h0, 1, 32'h1234, 1); tick();
    upd(32'h600, 1, 0, 1, 32'h7000, 0, 32'h604, 1); tick();
    rst = 1'b1;
    bif.btb_flush = 1'b1;
    look(32'h600, 1, 1, 32'h7000); upd(32'h600, 0, 1, 1, 32'h8000, 0, 32'h604, 1); tick();
    look(32'h600, 0, 0, 32'h604); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
